// File: rtl/ex_div_if.sv
// Issue/ctrl-side bundle for the EX-stage divider: operation request in, result and
// pipeline pause/unpause requests out.
interface ex_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [4:0]       rd_in;
  logic             flush;
  logic             div_pause_signal;
  logic             div_unpause_signal;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic [4:0]       rd_out;
  logic             busy;

  modport master (
    output start, op, dividend, divisor, rd_in, flush,
    input  div_pause_signal, div_unpause_signal, result, result_valid, rd_out, busy
  );

  modport slave (
    input  start, op, dividend, divisor, rd_in, flush,
    output div_pause_signal, div_unpause_signal, result, result_valid, rd_out, busy
  );
endinterface

// File: rtl/ex_div.sv
// RV32M DIV/DIVU/REM/REMU by restoring division on magnitudes, one quotient bit per cycle.
// Result 33 cycles after start (1 for divide-by-zero/overflow); start ignored while busy, flush aborts silently.
module ex_div #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  ex_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    count;
  logic             sel_rem;
  logic             q_neg;
  logic             r_neg;
  logic [4:0]       rd_q;
  logic [WIDTH-1:0] result_q;
  logic             result_valid_q;
  logic             unpause_q;
  logic [4:0]       rd_out_q;

  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             overflow;

  assign is_signed = !bus.op[0];
  assign a_neg     = is_signed & bus.dividend[WIDTH-1];
  assign b_neg     = is_signed & bus.divisor[WIDTH-1];
  assign a_mag     = a_neg ? -bus.dividend : bus.dividend;
  assign b_mag     = b_neg ? -bus.divisor : bus.divisor;
  assign div_zero  = (bus.divisor == '0);
  assign overflow  = is_signed && (bus.dividend == MIN_NEG) && (bus.divisor == '1);

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Partial remainder stays below the divisor, so the extra bit of trial is a clean sign.
  always_comb begin
    trial = {rem, quo[WIDTH-1]} - {1'b0, dvsr};
    if (!trial[WIDTH]) begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = {rem[WIDTH-2:0], quo[WIDTH-1]};
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
    q_fix = q_neg ? -quo_nxt : quo_nxt;
    r_fix = r_neg ? -rem_nxt : rem_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rem            <= '0;
      quo            <= '0;
      dvsr           <= '0;
      count          <= '0;
      sel_rem        <= 1'b0;
      q_neg          <= 1'b0;
      r_neg          <= 1'b0;
      rd_q           <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      unpause_q      <= 1'b0;
      rd_out_q       <= '0;
    end else begin
      result_valid_q <= 1'b0;
      unpause_q      <= 1'b0;
      if (bus.flush) begin
        state <= IDLE;
        count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              sel_rem <= bus.op[1];
              rd_q    <= bus.rd_in;
              q_neg   <= a_neg ^ b_neg;
              r_neg   <= a_neg;
              dvsr    <= b_mag;
              count   <= '0;
              if (div_zero || overflow) begin
                state          <= DONE;
                result_valid_q <= 1'b1;
                unpause_q      <= 1'b1;
                rd_out_q       <= bus.rd_in;
                if (div_zero) result_q <= bus.op[1] ? bus.dividend : '1;
                else          result_q <= bus.op[1] ? '0 : MIN_NEG;
              end else begin
                state <= CALC;
                rem   <= '0;
                quo   <= a_mag;
              end
            end
          end
          CALC: begin
            rem   <= rem_nxt;
            quo   <= quo_nxt;
            count <= count + CW'(1);
            if (count == CW'(WIDTH-1)) begin
              state          <= DONE;
              result_valid_q <= 1'b1;
              unpause_q      <= 1'b1;
              rd_out_q       <= rd_q;
              result_q       <= sel_rem ? r_fix : q_fix;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.div_pause_signal   = !bus.flush && (((state == IDLE) && bus.start) || (state == CALC));
  assign bus.div_unpause_signal = unpause_q;
  assign bus.result             = result_q;
  assign bus.result_valid       = result_valid_q;
  assign bus.rd_out             = rd_out_q;
  assign bus.busy               = (state != IDLE);
endmodule

// File: tb/tb_ex_div.sv
// Directed and random checks of ex_div against a cycle-count/arithmetic reference model.
module tb_ex_div;
  localparam int W = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  ex_div_if #(.WIDTH(W)) bus ();
  ex_div #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural RV32M result, written straight from the ISA rules.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, output bit special);
    special = (b == 0) || (!op[0] && a == MIN && b == 32'hFFFF_FFFF);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (special) return op[1] ? 32'h0 : MIN;
    case (op)
      2'd0:    return $signed(a) / $signed(b);
      2'd1:    return a / b;
      2'd2:    return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return MIN;
      4:       return 32'h7FFF_FFFF;
      5:       return $urandom_range(0, 20);
      6:       return 32'(0 - $urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Model: an accepted start occupies 33 cycles (1 if special); the strobe is in the last one.
  int          m_left    = 0;
  int          m_started = 0;
  logic [31:0] m_res     = 0;
  logic [4:0]  m_rd      = 0;
  logic        exp_vld   = 0;
  logic [31:0] exp_res   = 0;
  logic [4:0]  exp_rd    = 0;

  initial forever begin
    @(posedge clk) cyc++;
  end

  initial begin
    bit sp;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_left  = 0;
        exp_vld = 0;
        exp_res = 0;
        exp_rd  = 0;
      end else begin
        exp_vld = 0;
        if (bus.flush) m_left = 0;
        else if (m_left > 0) m_left--;
        else if (bus.start) begin
          m_res  = ref_div(bus.op, bus.dividend, bus.divisor, sp);
          m_rd   = bus.rd_in;
          m_left = sp ? 1 : 33;
          m_started++;
        end
        if (m_left == 1) begin
          exp_vld = 1;
          exp_res = m_res;
          exp_rd  = m_rd;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    check("result_valid", 32'(bus.result_valid), 32'(exp_vld));
    check("unpause", 32'(bus.div_unpause_signal), 32'(exp_vld));
    check("busy", 32'(bus.busy), 32'(m_left > 0));
    check("pause", 32'(bus.div_pause_signal),
          32'(!bus.flush && ((m_left == 0 && bus.start) || m_left >= 2)));
    check("result", bus.result, exp_res);
    check("rd_out", 32'(bus.rd_out), 32'(exp_rd));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
    int s;
    int np;
    logic [4:0] rd;
    rd = 5'($urandom);
    bus.op = op; bus.dividend = a; bus.divisor = b; bus.rd_in = rd; bus.start = 1'b1;
    #1 check({name, " pause c0"}, 32'(bus.div_pause_signal), 32'd1);
    s = cyc;
    tick();
    bus.start = 1'b0;
    np = 0;
    while (!bus.result_valid && cyc - s < 60) begin
      if (bus.div_pause_signal) np++;
      tick();
    end
    check({name, " latency"}, 32'(cyc - s), 32'(exp_lat));
    check({name, " result"}, bus.result, exp_r);
    check({name, " unpause"}, 32'(bus.div_unpause_signal), 32'd1);
    check({name, " rd_out"}, 32'(bus.rd_out), 32'(rd));
    check({name, " pause cycles"}, 32'(np), 32'(exp_lat - 1));
    tick();
  endtask

  initial begin
    bit sp;
    int s;
    int nv;
    int base;
    int guard;
    bus.start = 0; bus.flush = 0; bus.op = 0; bus.dividend = 0; bus.divisor = 0; bus.rd_in = 0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst result", bus.result, 32'h0);
    check("rst rd_out", 32'(bus.rd_out), 32'h0);
    check("rst valid", 32'(bus.result_valid), 32'h0);
    check("rst unpause", 32'(bus.div_unpause_signal), 32'h0);
    check("rst busy", 32'(bus.busy), 32'h0);
    check("rst pause", 32'(bus.div_pause_signal), 32'h0);
    rst_n = 1'b1;
    tick();

    check("model divu 100/7", ref_div(2'd1, 32'd100, 32'd7, sp), 32'd14);
    check("model rem -7/2", ref_div(2'd2, 32'hFFFF_FFF9, 32'd2, sp), 32'hFFFF_FFFF);
    check("model div -7/2", ref_div(2'd0, 32'hFFFF_FFF9, 32'd2, sp), 32'hFFFF_FFFD);
    check("model div 5/0", ref_div(2'd0, 32'd5, 32'd0, sp), 32'hFFFF_FFFF);
    check("model remu 5/0", ref_div(2'd3, 32'd5, 32'd0, sp), 32'd5);
    check("model div ovf", ref_div(2'd0, MIN, 32'hFFFF_FFFF, sp), MIN);
    check("model rem ovf", ref_div(2'd2, MIN, 32'hFFFF_FFFF, sp), 32'h0);

    run_op("divu 100/7", 2'd1, 32'd100, 32'd7, 32'd14, 33);
    run_op("rem -7/2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("div -7/2", 2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem 7/-2", 2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("divu max/1", 2'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
    run_op("div 5/0", 2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu 5/0", 2'd3, 32'd5, 32'd0, 32'd5, 1);
    run_op("div ovf", 2'd0, MIN, 32'hFFFF_FFFF, MIN, 1);
    run_op("rem ovf", 2'd2, MIN, 32'hFFFF_FFFF, 32'h0, 1);

    // Flush mid-divide, then a fresh divide from the first idle cycle after it.
    bus.op = 2'd0; bus.dividend = 32'd20; bus.divisor = 32'd3; bus.rd_in = 5'd3; bus.start = 1'b1;
    s = cyc;
    tick();
    bus.start = 1'b0;
    while (cyc - s < 10) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush idle c11", 32'(bus.busy), 32'h0);
    tick();
    bus.op = 2'd1; bus.dividend = 32'd9; bus.divisor = 32'd3; bus.rd_in = 5'd9; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    nv = 0;
    while (!bus.result_valid && cyc - s < 80) begin
      if (bus.div_unpause_signal) nv++;
      tick();
    end
    check("flush no strobe", 32'(nv), 32'h0);
    check("post-flush latency", 32'(cyc - s), 32'd45);
    check("post-flush result", bus.result, 32'd3);
    tick();

    // Reset in the middle of a divide.
    bus.op = 2'd1; bus.dividend = 32'd1000; bus.divisor = 32'd3; bus.rd_in = 5'd7; bus.start = 1'b1;
    s = cyc;
    tick();
    bus.start = 1'b0;
    while (cyc - s < 15) tick();
    rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(bus.busy), 32'h0);
    check("midrst result", bus.result, 32'h0);
    check("midrst rd_out", 32'(bus.rd_out), 32'h0);
    check("midrst pause", 32'(bus.div_pause_signal), 32'h0);
    tick();
    rst_n = 1'b1;
    nv = 0;
    repeat (40) begin
      tick();
      if (bus.result_valid || bus.div_unpause_signal) nv++;
    end
    check("midrst no strobe", 32'(nv), 32'h0);

    // flush beats start in the same cycle.
    bus.op = 2'd1; bus.dividend = 32'd50; bus.divisor = 32'd5; bus.start = 1'b1; bus.flush = 1'b1;
    #1 check("start+flush pause", 32'(bus.div_pause_signal), 32'h0);
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("start+flush idle", 32'(bus.busy), 32'h0);
    tick();

    // Random traffic: starts also land while busy; occasional flushes.
    base  = m_started;
    guard = 0;
    while (m_started - base < 1000 && guard < 80000) begin
      bus.op       = 2'($urandom_range(0, 3));
      bus.dividend = pick();
      bus.divisor  = pick();
      bus.rd_in    = 5'($urandom);
      bus.start    = ($urandom_range(0, 1) == 1);
      bus.flush    = ($urandom_range(0, 299) == 0);
      tick();
      guard++;
    end
    bus.start = 1'b0;
    bus.flush = 1'b0;
    repeat (40) tick();
    check("random ops accepted", 32'(m_started - base), 32'd1000);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
